// File: rtl/rx_symbol_aligner.sv
// K28.5 word aligner: searches all 10 bit offsets of a two-word history for a comma,
// runs an UNLOCKED/ALIGN/LOCKED state machine and emits symbol-aligned words.
`timescale 1ns/1ps
module rx_symbol_aligner #(
    parameter int                    DATA_WIDTH    = 10,
    parameter logic [DATA_WIDTH-1:0] COMMA_NEG     = 10'h17C,
    parameter logic [DATA_WIDTH-1:0] COMMA_POS     = 10'h283,
    parameter int                    LOCK_COUNT    = 3,
    parameter int                    UNLOCK_COUNT  = 4,
    parameter int                    ALIGN_TIMEOUT = 64
) (
    input  logic                  CLK,
    input  logic                  Rst_n,
    input  logic                  Data_en,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_valid,
    output logic                  Comma_pulse,
    output logic                  Symbol_lock,
    output logic [3:0]            Lock_offset,
    output logic                  Realign_pulse
);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_ALIGN, ST_LOCKED} state_t;

    localparam logic [3:0] LOCK_C   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_COUNT);
    localparam logic [7:0] TMO_C    = 8'(ALIGN_TIMEOUT);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   w0_q, w0_d, w1_q, w1_d;
    logic [3:0]              cand_q, cand_d, cnt_q, cnt_d, mis_q, mis_d, off_q, off_d;
    logic [7:0]              tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    valid_q, valid_d, comma_q, comma_d, realign_q, realign_d;

    logic [2*DATA_WIDTH-1:0] hist;
    logic [DATA_WIDTH-1:0]   win [DATA_WIDTH];
    logic [DATA_WIDTH-1:0]   match;
    logic                    any_match;
    logic [3:0]              low_off;

    // Descending scan so the last hit written is the lowest matching offset.
    always_comb begin
        hist      = {w0_q, w1_q};
        any_match = 1'b0;
        low_off   = '0;
        for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
            win[k]   = hist[k +: DATA_WIDTH];
            match[k] = (win[k] == COMMA_NEG) || (win[k] == COMMA_POS);
            if (match[k]) begin
                any_match = 1'b1;
                low_off   = 4'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        w0_d      = w0_q;
        w1_d      = w1_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        mis_d     = mis_q;
        tmo_d     = tmo_q;
        off_d     = off_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        comma_d   = 1'b0;
        realign_d = 1'b0;
        if (Data_en) begin
            w1_d = w0_q;
            w0_d = Data_in;
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (any_match) begin
                        if (LOCK_COUNT == 1) begin
                            state_d   = ST_LOCKED;
                            off_d     = low_off;
                            mis_d     = '0;
                            realign_d = 1'b1;
                        end else begin
                            state_d = ST_ALIGN;
                            cand_d  = low_off;
                            cnt_d   = 4'd1;
                            tmo_d   = '0;
                        end
                    end
                end
                ST_ALIGN: begin
                    if (match[cand_q]) begin
                        tmo_d = '0;
                        if (cnt_q + 4'd1 == LOCK_C) begin
                            state_d   = ST_LOCKED;
                            off_d     = cand_q;
                            cnt_d     = '0;
                            mis_d     = '0;
                            realign_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (any_match) begin
                        cand_d = low_off;
                        cnt_d  = 4'd1;
                        tmo_d  = '0;
                    end else if (tmo_q + 8'd1 == TMO_C) begin
                        state_d = ST_UNLOCKED;
                        tmo_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (match[off_q]) begin
                        mis_d = '0;
                    end else if (any_match) begin
                        if (mis_q + 4'd1 == UNLOCK_C) begin
                            state_d = ST_UNLOCKED;
                            mis_d   = '0;
                        end else begin
                            mis_d = mis_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
            // Select with the offset in force after this edge so the locking comma is emitted valid.
            valid_d = (state_d == ST_LOCKED);
            dout_d  = win[off_d];
            comma_d = valid_d && ((dout_d == COMMA_NEG) || (dout_d == COMMA_POS));
        end
    end

    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_UNLOCKED;
            w0_q      <= '0;
            w1_q      <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            mis_q     <= '0;
            tmo_q     <= '0;
            off_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            comma_q   <= 1'b0;
            realign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w0_q      <= w0_d;
            w1_q      <= w1_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
            tmo_q     <= tmo_d;
            off_q     <= off_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            comma_q   <= comma_d;
            realign_q <= realign_d;
        end
    end

    assign Data_out      = dout_q;
    assign Data_valid    = valid_q;
    assign Comma_pulse   = comma_q;
    assign Symbol_lock   = (state_q == ST_LOCKED);
    assign Lock_offset   = off_q;
    assign Realign_pulse = realign_q;

endmodule

// File: doc/rx_symbol_aligner.md
Name: rx_symbol_aligner

Overview:
- Sits between Serial_to_Parallel and the comma detection / elasticBuffer stages in the RX path.
- Takes unaligned 10-bit words from the deserializer and searches all 10 bit offsets for K28.5.
- Runs a lock state machine and outputs symbol-aligned 10-bit words with valid, comma and lock indications.
- Single word clock.

Parameters:
- DATA_WIDTH, 10, symbol width. Fixed at 10; other values are not supported.
- COMMA_NEG, 10'h17C, K28.5 RD- (abcdeifghj = 0011111010, bit a at bit 0).
- COMMA_POS, 10'h283, K28.5 RD+ (1100000101, bit a at bit 0).
- LOCK_COUNT, 3, consecutive same-offset commas needed to lock (range 1..15).
- UNLOCK_COUNT, 4, consecutive other-offset commas that drop lock (range 1..15).
- ALIGN_TIMEOUT, 64, words in ALIGN without a cand_off comma before returning to UNLOCKED (range 1..255).

Ports:
- CLK, input, 1, word clock; all logic on rising edge.
- Rst_n, input, 1, asynchronous active-low reset.
- Data_en, input, 1, Data_in holds a new word this cycle.
- Data_in, input, 10, raw deserialized word; bit 0 = earliest received bit.
- Data_out, output, 10, aligned symbol.
- Data_valid, output, 1, Data_out is a valid locked symbol.
- Comma_pulse, output, 1, Data_out is COMMA_NEG or COMMA_POS; qualified by Data_valid.
- Symbol_lock, output, 1, FSM is in LOCKED.
- Lock_offset, output, 4, offset in use, 0..9.
- Realign_pulse, output, 1, one-cycle pulse on every transition into LOCKED.

Behaviour:
- Reset (async, Rst_n=0):
  - All outputs 0.
  - w0 and w1 history registers 0.
  - FSM = UNLOCKED; all counters 0; cand_off = 0.
- History: when Data_en=1, w1<=w0 and w0<=Data_in. When Data_en=0, all registers hold and registered outputs hold, except pulses, which clear to 0.
- Window: hist = {w0,w1} (20 bits, w1 older). window[k] = hist[k+9:k] for k = 0..9.
- Match: match[k] = 1 when window[k] equals COMMA_NEG or COMMA_POS. Evaluated only in cycles where Data_en=1.
- Datapath latency: on an enabled edge, Data_out <= window[Lock_offset]. A word presented on Data_in at enabled edge n appears on Data_out after enabled edge n+2 when Lock_offset=0.
- Output flags: Comma_pulse and Data_valid are registered with Data_out. Data_valid = 1 only when the FSM state at that edge is LOCKED; the output edge of the transition into LOCKED already has Data_valid=1.
- FSM state UNLOCKED:
  - Data_valid=0.
  - If any match[k]=1, pick the lowest such k; cand_off<=k, cnt<=1, tmo<=0, go to ALIGN.
  - If LOCK_COUNT=1, go directly to LOCKED instead.
- FSM state ALIGN:
  - match[cand_off]=1: cnt++, tmo<=0. When cnt+1 = LOCK_COUNT, go to LOCKED, set Lock_offset<=cand_off and pulse Realign_pulse.
  - Otherwise, if any other match exists: restart with the lowest matching offset, cnt<=1, tmo<=0.
  - Otherwise: tmo++. When tmo+1 = ALIGN_TIMEOUT, go to UNLOCKED.
- FSM state LOCKED:
  - match[Lock_offset]=1 (highest priority, even if other offsets also match): mis<=0.
  - Otherwise, if any other match exists: mis++. When mis+1 = UNLOCK_COUNT, go to UNLOCKED, mis<=0, Symbol_lock<=0.
  - Otherwise: mis holds.
  - Lock_offset never changes while in LOCKED.
- Mid-operation reset: returns to the reset state immediately and asynchronously; no partial output is emitted after reset release.
- Wrap-around: no counter wraps. cnt, mis and tmo saturate at their thresholds by construction.
- Ignored codes: non-comma K codes and invalid 10b codes are passed through unchanged; only K28.5 drives alignment.

Test Plan:
- Reset: assert Rst_n=0 mid-stream -> all outputs 0 within the same cycle. Release with Data_in=0 and Data_en=1 -> Symbol_lock stays 0 and Data_valid stays 0.
- Lock at offset 3: serial stream of D-symbols with K28.5 (0x17C / 0x283, alternating disparity) every 4th symbol, shifted by 3 bits into the words -> LOCKED after the 3rd comma, Lock_offset=3, one Realign_pulse. Thereafter Data_out reproduces the symbols with Comma_pulse on each K28.5 and 2-cycle latency.
- ALIGN restart: 2 commas at offset 5, then 1 at offset 7, then 3 at offset 7 -> candidate moves to 7; lock reached on the 3rd consecutive offset-7 comma, with cnt starting at 1 on the first offset-7 comma.
- Timeout: 1 comma, then 64 comma-free enabled words -> back to UNLOCKED after the 64th; a further 63 words gives no timeout in a repeat run.
- Loss of lock: locked at 3, then 4 commas at offset 8 with no offset-3 comma -> Symbol_lock drops after the 4th. Repeat with an offset-3 comma after the 3rd -> lock is retained.
- Stall: toggle Data_en 1/0 every cycle during lock acquisition -> identical Data_out sequence and lock point counted in enabled cycles; pulses last exactly one cycle.
